// File: rtl/osecpu_kbd_pkg.sv
// Shared keypad geometry and the frame-result encoding {present, code}.
// Pure definitions: no latency, no flow control.
package osecpu_kbd_pkg;

   localparam int NCOL  = 4;
   localparam int NROW  = 4;
   localparam int KEY_W = 4;

   typedef struct packed {
      logic             present;
      logic [KEY_W-1:0] code;
   } frame_res_t;

   localparam frame_res_t RES_NONE = '{present: 1'b0, code: '0};

   // Bit r*NCOL+c of hits is set when key (row r, column c) was seen low,
   // so a single set bit's index is directly its key code.
   // Two or more hits are ambiguous and fold into "none".
   function automatic frame_res_t classify(input logic [NROW*NCOL-1:0] hits);
      frame_res_t res;
      int         n;
      int         idx;
      res = RES_NONE;
      n   = 0;
      idx = 0;
      for (int i = 0; i < NROW*NCOL; i++) begin
         if (hits[i]) begin
            n   = n + 1;
            idx = i;
         end
      end
      if (n == 1) begin
         res.present = 1'b1;
         res.code    = KEY_W'(idx);
      end
      return res;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous board inputs; latency 2 cycles.
// No flow control: samples every cycle, reset value chosen per input's idle level.
module sync2 #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, frame debounce, key events; event 1 cycle after frame end.
// Events are held in key_valid until key_ack; an unacknowledged event overwritten sets sticky overrun.
module keypad_scanner
   import osecpu_kbd_pkg::*;
#(
   parameter int CLK_DIV  = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NROW-1:0]  row,
   output logic [NCOL-1:0]  col,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   input  logic             key_ack,
   output logic             key_down,
   output logic             overrun
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int COL_W = $clog2(NCOL);
   localparam int CNT_W = 4;

   logic [NROW-1:0]      row_s;
   logic [DIV_W-1:0]     div_cnt;
   logic [COL_W-1:0]     col_idx;
   logic [NROW*NCOL-1:0] hits_q;
   logic [NROW*NCOL-1:0] hits_now;
   logic                 slot_end;
   logic                 frame_end;
   frame_res_t           res;
   frame_res_t           cand;
   frame_res_t           cand_nxt;
   frame_res_t           stable;
   logic [CNT_W-1:0]     db_cnt;
   logic [CNT_W-1:0]     cnt_nxt;
   logic                 promote;
   logic                 evt;
   logic                 ack_taken;

   // Rows idle high through the pull-ups, so the synchronizer resets to all ones.
   sync2 #(
      .WIDTH   (NROW),
      .RST_VAL ({NROW{1'b1}})
   ) u_row_sync (
      .clk   (clk),
      .reset (reset),
      .d     (row),
      .q     (row_s)
   );

   assign slot_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign frame_end = slot_end && (col_idx == COL_W'(NCOL - 1));

   always_comb begin
      col          = '1;
      col[col_idx] = 1'b0;
   end

   // Merge the current column's rows into the frame so the last column
   // can be classified in the same cycle it is sampled.
   always_comb begin
      hits_now = hits_q;
      for (int r = 0; r < NROW; r++) begin
         hits_now[r*NCOL + int'(col_idx)] = ~row_s[r];
      end
   end

   assign res = classify(hits_now);

   always_comb begin
      cand_nxt = cand;
      cnt_nxt  = db_cnt;
      if (res == cand) begin
         cnt_nxt = (db_cnt == '1) ? db_cnt : db_cnt + CNT_W'(1);
      end else begin
         cand_nxt = res;
         cnt_nxt  = CNT_W'(1);
      end
   end

   assign promote   = frame_end && (cnt_nxt >= CNT_W'(DEBOUNCE)) && (cand_nxt != stable);
   assign evt       = promote && cand_nxt.present;
   assign ack_taken = key_valid && key_ack;
   assign key_down  = stable.present;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt   <= '0;
         col_idx   <= '0;
         hits_q    <= '0;
         cand      <= RES_NONE;
         stable    <= RES_NONE;
         db_cnt    <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (slot_end) begin
            div_cnt <= '0;
            col_idx <= col_idx + COL_W'(1);
            hits_q  <= hits_now;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         if (frame_end) begin
            cand   <= cand_nxt;
            db_cnt <= cnt_nxt;
            if (promote) begin
               stable <= cand_nxt;
            end
         end

         // A new event outranks an ack landing in the same cycle.
         if (evt) begin
            key_code  <= cand_nxt.code;
            key_valid <= 1'b1;
            if (key_valid && !key_ack) begin
               overrun <= 1'b1;
            end
         end else if (ack_taken) begin
            key_valid <= 1'b0;
         end
      end
   end

endmodule
